mini_bit_out_port: RTL and testbench

//   Output-side peripheral for mini_bit: the consumer end of the CPU's OUT strobe.

---
 rtl/mini_bit_out_port.sv | 124 ++++++++++++
 tb/tb_mini_bit_out_port.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mini_bit_out_port.sv
// mini_bit OUT-strobe consumer: edge-detects tx, buffers bus bytes in a FWFT FIFO, drains over valid/ready.
// Optional dropped-byte counter is built only when OUT_PORT_DROP_CNT_EN is defined.
module mini_bit_out_port #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [7:0]       bus,
  input  logic             tx,
  output logic             rx,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             tx_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [DEPTH];

  logic push_s, pop_s, full_s, wr_en_s, drop_s, out_valid_s;

  assign out_valid_s = (count_q != {CNT_W{1'b0}});
  assign full_s      = (count_q == CNT_W'(DEPTH));
  assign push_s      = tx & ~tx_q;
  assign pop_s       = out_valid_s & out_ready;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign wr_en_s     = push_s & (~full_s | pop_s);
  assign drop_s      = push_s & full_s & ~pop_s;

  // Next-state for pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control registers, cleared asynchronously by clr_n.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tx_q       <= 1'b0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      tx_q       <= tx;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents survive reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= bus;
    end
  end

  assign out_valid = out_valid_s;
  assign out_data  = out_valid_s ? mem_q[rd_ptr_q] : 8'h00;
  assign rx        = ~full_s;
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef OUT_PORT_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-byte counter.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_mini_bit_out_port.sv
// Directed self-checking bench for mini_bit_out_port (DEPTH=4).
module tb_mini_bit_out_port;

  logic       clk;
  logic       clr_n;
  logic [7:0] bus;
  logic       tx;
  logic       rx;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_checks;
  int n_fail;
  logic [7:0] sink_q[$];

`ifdef OUT_PORT_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP = 8'd1;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  mini_bit_out_port #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus), .tx(tx), .rx(rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_n && out_valid && out_ready) sink_q.push_back(out_data);
  end

  task automatic do_reset();
    @(negedge clk);
    tx = 1'b0; out_ready = 1'b0; clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    bus = b; tx = 1'b1;
    @(negedge clk);
    tx = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; tx = 1'b0; bus = 8'h00; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (rx !== 1'b1) begin n_fail++; $display("FAIL reset_rx got %b exp 1", rx); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop got %h exp 00", drop_cnt); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", out_data); end
    clr_n = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus = 8'hA5; tx = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count cyc %0d got %0d exp 1", c, count); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid cyc %0d got %b exp 1", c, out_valid); end
      n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data cyc %0d got %h exp a5", c, out_data); end
      bus = 8'h3C;
    end
    tx = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_drain_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_ordering();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    sink_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (sink_q.size() !== 3) begin
      n_fail++; $display("FAIL order_size got %0d exp 3", sink_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (sink_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL order_byte%0d got %h exp %h", i, sink_q[i], exp_b[i]); end
      end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_valid got %b exp 0", out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL order_count got %0d exp 0", count); end
  endtask

  task automatic test_full_drop();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus = 8'(i); tx = 1'b1;
      @(negedge clk);
      tx = 1'b0;
      if (i == 3) begin
        n_checks++; if (rx !== 1'b1) begin n_fail++; $display("FAIL full_rx_at3 got %b exp 1", rx); end
      end else if (i == 4) begin
        n_checks++; if (rx !== 1'b0) begin n_fail++; $display("FAIL full_rx_at4 got %b exp 0", rx); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count_at4 got %0d exp 4", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_at4 got %b exp 0", overflow); end
      end else if (i == 5) begin
        n_checks++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL full_head_hold got %h exp 01", out_data); end
      end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %b exp 1", overflow); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
    n_checks++; if (drop_cnt !== EXP_DROP) begin n_fail++; $display("FAIL full_drop_cnt got %h exp %h", drop_cnt, EXP_DROP); end
    sink_q.delete();
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (sink_q.size() !== 4) begin
      n_fail++; $display("FAIL full_drain_size got %0d exp 4", sink_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (sink_q[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL full_drain_byte%0d got %h exp %h", i, sink_q[i], 8'(i + 1)); end
      end
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drain_count got %0d exp 0", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [5];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3; exp_b[3] = 8'hA4; exp_b[4] = 8'h77;
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(exp_b[i]);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL pp_fill_count got %0d exp 4", count); end
    sink_q.delete();
    @(negedge clk);
    bus = 8'h77; tx = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    tx = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL pp_count got %0d exp 4", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_ovf got %b exp 0", overflow); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL pp_drop got %h exp 00", drop_cnt); end
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (sink_q.size() !== 5) begin
      n_fail++; $display("FAIL pp_drain_size got %0d exp 5", sink_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++; if (sink_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL pp_byte%0d got %h exp %h", i, sink_q[i], exp_b[i]); end
      end
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL pp_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL ar_pre_count got %0d exp 3", count); end
    @(negedge clk);
    bus = 8'h5A;
    #2;
    tx = 1'b1; clr_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL ar_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b exp 0", out_valid); end
    n_checks++; if (rx !== 1'b1) begin n_fail++; $display("FAIL ar_rx got %b exp 1", rx); end
    #1;
    clr_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL ar_push_count cyc %0d got %0d exp 1", c, count); end
      n_checks++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL ar_push_data cyc %0d got %h exp 5a", c, out_data); end
    end
    tx = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_single_write();
    test_ordering();
    test_full_drop();
    test_full_push_pop();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
